// File: rtl/instruction_fetch_pkg.sv
// Shared types and default geometry for the instruction fetch engine.
package instruction_fetch_pkg;

    localparam int unsigned DefIAddrW     = 12;
    localparam int unsigned DefInstWBytes = 2;
    localparam int unsigned DefByteW      = 8;

    // Fetch engine control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch engine: issues INST_W_BYTES sequential byte reads to a
// 1-cycle-latency memory, assembles them little-endian and hands the word to
// the decoder over valid/ready. A flush abandons any in-flight or held fetch.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned I_ADDR_W     = DefIAddrW,
    parameter int unsigned INST_W_BYTES = DefInstWBytes,
    parameter int unsigned BYTE_W       = DefByteW
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [I_ADDR_W-1:0]            pc,
    input  logic                           pc_valid,
    output logic                           fetch_ready,
    input  logic                           flush,
    output logic [I_ADDR_W-1:0]            imem_addr,
    output logic                           imem_rd_en,
    input  logic [BYTE_W-1:0]              imem_rdata,
    output logic [INST_W_BYTES*BYTE_W-1:0] inst,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic                           inst_fault
);

    localparam int unsigned CNT_W  = $clog2(INST_W_BYTES + 1);
    localparam int unsigned INST_W = INST_W_BYTES * BYTE_W;
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(INST_W_BYTES - 1);

    fetch_state_e        state_q;
    // Index of the address being presented; byte cnt_q-1 is returning this cycle.
    logic [CNT_W-1:0]    cnt_q;
    logic [I_ADDR_W-1:0] imem_addr_q;
    logic                imem_rd_en_q;
    logic [INST_W-1:0]   inst_q;
    logic                inst_valid_q;
    logic                inst_fault_q;

    // Ready only when idle; flush blocks acceptance in the same cycle.
    always_comb begin
        fetch_ready = (state_q == IDLE) && !flush;
    end

    // Fetch FSM with registered memory strobe, address and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            imem_addr_q  <= '0;
            imem_rd_en_q <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_fault_q <= 1'b0;
        end else if (flush) begin
            state_q      <= IDLE;
            imem_rd_en_q <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            // Data for the previous address arrives while in ISSUE/DRAIN.
            if (state_q == ISSUE || state_q == DRAIN) begin
                for (int unsigned i = 0; i < INST_W_BYTES; i++) begin
                    if (cnt_q == CNT_W'(i + 1)) begin
                        inst_q[i*BYTE_W +: BYTE_W] <= imem_rdata;
                    end
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (pc_valid) begin
                        state_q      <= ISSUE;
                        cnt_q        <= '0;
                        imem_addr_q  <= pc;
                        imem_rd_en_q <= 1'b1;
                        inst_fault_q <= (pc % I_ADDR_W'(INST_W_BYTES)) != '0;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastIdx) begin
                        state_q      <= DRAIN;
                        imem_rd_en_q <= 1'b0;
                    end else begin
                        imem_addr_q <= imem_addr_q + I_ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state_q      <= HOLD;
                    inst_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (inst_ready) begin
                        state_q      <= IDLE;
                        inst_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_addr  = imem_addr_q;
    assign imem_rd_en = imem_rd_en_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign inst_fault = inst_fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: byte memory model plus a reference that builds
// each expected word straight from memory contents and the fetch address.
module tb_instruction_fetch;

    localparam int AW = 12;
    localparam int N  = 2;
    localparam int BW = 8;
    localparam int MEM_SIZE = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   pc;
    logic            pc_valid;
    logic            fetch_ready;
    logic            flush;
    logic [AW-1:0]   imem_addr;
    logic            imem_rd_en;
    logic [BW-1:0]   imem_rdata;
    logic [N*BW-1:0] inst;
    logic            inst_valid;
    logic            inst_ready;
    logic            inst_fault;

    logic [BW-1:0] mem [MEM_SIZE];

    int checks = 0;
    int errors = 0;

    instruction_fetch #(
        .I_ADDR_W    (AW),
        .INST_W_BYTES(N),
        .BYTE_W      (BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .fetch_ready(fetch_ready),
        .flush      (flush),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_fault (inst_fault)
    );

    always #5 clk = ~clk;

    // Synchronous memory, one cycle of read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; inputs are then driven and outputs sampled
    // a little after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*BW-1:0] ref_inst(input int base);
        logic [N*BW-1:0] r;
        for (int k = 0; k < N; k++) r[k*BW +: BW] = mem[(base + k) % MEM_SIZE];
        return r;
    endfunction

    // Full fetch with timing checks; decoder stalls for 'stall' cycles in HOLD.
    task automatic do_fetch(input int addr, input int stall);
        logic [N*BW-1:0] exp_inst;
        logic            exp_fault;
        exp_inst  = ref_inst(addr);
        exp_fault = (addr % N) != 0;
        pc = AW'(addr);
        pc_valid = 1'b1;
        #1;
        chk("accept_ready", 32'(fetch_ready), 32'd1);
        for (int k = 0; k < N; k++) begin
            cyc();
            pc_valid = 1'b0;
            #1;
            chk("issue_rd_en", 32'(imem_rd_en), 32'd1);
            chk("issue_addr", 32'(imem_addr), 32'((addr + k) % MEM_SIZE));
            chk("issue_no_valid", 32'(inst_valid), 32'd0);
        end
        cyc();
        chk("drain_rd_en", 32'(imem_rd_en), 32'd0);
        chk("drain_no_valid", 32'(inst_valid), 32'd0);
        cyc();
        chk("hold_valid", 32'(inst_valid), 32'd1);
        chk("hold_inst", 32'(inst), 32'(exp_inst));
        chk("hold_fault", 32'(inst_fault), 32'(exp_fault));
        chk("hold_not_ready", 32'(fetch_ready), 32'd0);
        for (int d = 0; d < stall; d++) begin
            cyc();
            chk("stall_inst", 32'(inst), 32'(exp_inst));
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_rd_en", 32'(imem_rd_en), 32'd0);
            chk("stall_not_ready", 32'(fetch_ready), 32'd0);
        end
        inst_ready = 1'b1;
        #1;
        chk("handoff_ready_no_comb", 32'(fetch_ready), 32'd0);
        cyc();
        inst_ready = 1'b0;
        #1;
        chk("after_handoff_valid", 32'(inst_valid), 32'd0);
        chk("after_handoff_ready", 32'(fetch_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = BW'($urandom);
        rst_n = 1'b0;
        pc = '0;
        pc_valid = 1'b0;
        flush = 1'b0;
        inst_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fault", 32'(inst_fault), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Basic fetch with known bytes.
        mem[12'h010] = 8'h34;
        mem[12'h011] = 8'h12;
        do_fetch(12'h010, 0);
        chk("basic_const_inst", 32'(ref_inst(12'h010)), 32'h1234);

        // Back-pressure.
        do_fetch(12'h100, 3);

        // Wrap and misalignment, then aligned neighbour.
        do_fetch(12'hFFF, 1);
        do_fetch(12'hFFE, 0);

        // Flush mid-fetch: accept at t0, flush during t0+2.
        pc = 12'h200;
        pc_valid = 1'b1;
        cyc();
        pc_valid = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_rd_en", 32'(imem_rd_en), 32'd0);
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_ready", 32'(fetch_ready), 32'd1);
        do_fetch(12'h020, 0);

        // Flush collides with pc_valid in IDLE.
        pc = 12'h300;
        pc_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("collide_ready", 32'(fetch_ready), 32'd0);
        cyc();
        pc_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("collide_rd_en", 32'(imem_rd_en), 32'd0);
        chk("collide_idle", 32'(fetch_ready), 32'd1);
        cyc();
        chk("collide_rd_en2", 32'(imem_rd_en), 32'd0);

        // Flush together with inst_ready in HOLD drops the instruction.
        pc = 12'h040;
        pc_valid = 1'b1;
        cyc();
        pc_valid = 1'b0;
        repeat (N + 1) cyc();
        chk("hflush_valid_before", 32'(inst_valid), 32'd1);
        flush = 1'b1;
        inst_ready = 1'b1;
        cyc();
        flush = 1'b0;
        inst_ready = 1'b0;
        #1;
        chk("hflush_valid", 32'(inst_valid), 32'd0);
        chk("hflush_ready", 32'(fetch_ready), 32'd1);

        // Async reset during ISSUE.
        pc = 12'h050;
        pc_valid = 1'b1;
        cyc();
        pc_valid = 1'b0;
        #1;
        chk("pre_rst_rd_en", 32'(imem_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_rd_en", 32'(imem_rd_en), 32'd0);
        chk("arst_ready", 32'(fetch_ready), 32'd1);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_inst", 32'(inst), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Randomized fetches against the reference.
        for (int r = 0; r < 24; r++) begin
            mem[$urandom_range(0, MEM_SIZE - 1)] = BW'($urandom);
            do_fetch(int'($urandom_range(0, MEM_SIZE - 1)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
